instr_mem_loader: RTL
=====================

Name: instr_mem_loader

Overview:
- Writer side of the instruction memory that the single-cycle CPU fetches from by PC.
- Receives a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes each word to consecutive byte addresses of instruction memory.
- Holds the CPU stalled while loading, then reports done or error.

Parameters:
- ADDR_W, 32, width of imem_addr; byte address, same format as PC.
- BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be 4-aligned.
- DEPTH_WORDS, 256, instruction memory capacity in words; larger lengths are rejected.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a load; honoured only in IDLE.
- in_valid  input  1  in_data holds a valid byte.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- imem_we  output  1  one-cycle instruction-memory write strobe.
- imem_addr  output  ADDR_W  byte address of the write.
- imem_wdata  output  32  instruction word to write.
- cpu_hold  output  1  stalls the CPU PC and register writes while high.
- busy  output  1  loader not in IDLE.
- done  output  1  one-cycle pulse when a load terminates, successful or not.
- error  output  1  sticky failure flag; cleared by the next accepted start.
- words_loaded  output  16  words written in the current or last load.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, all outputs 0, internal counters, shift register and checksum 0. Reset mid-load abandons the load immediately with no further writes.
- Handshake: a byte transfers on a clk edge where in_valid & in_ready. in_ready=1 only in LEN_HI, LEN_LO, DATA and CHK, so one byte per cycle is sustainable. in_data is ignored when no transfer occurs.
- Frame format: LEN_HI, LEN_LO (N = 16-bit word count, big-endian), then 4N payload bytes (MSB first per word), then one checksum byte = XOR of all payload bytes. Length bytes are excluded from the checksum.
- IDLE: on start=1, go to LEN_HI. On the same edge set cpu_hold=1, clear error, clear words_loaded, clear checksum.
- LEN_HI: on transfer, capture N[15:8] and go to LEN_LO.
- LEN_LO: on transfer, capture N[7:0], then:
  - N > DEPTH_WORDS: go to ERR.
  - N == 0: go to CHK.
  - otherwise: go to DATA with the byte index at 0.
- DATA:
  - Each transfer shifts the byte into a 32-bit register and XORs it into the checksum.
  - On the 4th byte: on the next edge, imem_we=1 for exactly one cycle, imem_wdata = assembled word, imem_addr = BASE_ADDR + 4*words_loaded (pre-increment value); words_loaded increments on that same edge.
  - The byte counter wraps 3->0 with no bubble, so the next word's bytes can arrive while the previous write is issuing.
  - When the 4N-th byte transfers, go to CHK.
- CHK: on transfer, compare the byte with the checksum.
  - Match: go to DONE.
  - Mismatch: go to ERR.
  - The final word's imem_we pulse can coincide with the CHK transfer cycle, and this is legal.
- DONE: done=1 for one cycle, cpu_hold=0 on the edge leaving DONE, return to IDLE.
- ERR: error=1 (sticky), done=1 for one cycle, cpu_hold=0, return to IDLE. Words already written stay in memory.
- start while busy is ignored. start and reset together: reset wins.
- imem_addr arithmetic is modulo 2^ADDR_W. With the DEPTH_WORDS check no wrap occurs for legal configurations.
- imem_we is never asserted outside DATA/CHK, or in the cycle after an ERR decision.
- busy = (state != IDLE). busy and cpu_hold are both high from the edge after start through the DONE/ERR cycle.

Test Plan:
- Normal load: start, then bytes 00 02 20 08 00 05 20 09 00 0A 0E.
  - Required: imem_we pulses at addr 0x0 with 0x20080005 and at addr 0x4 with 0x2009000A.
  - words_loaded=2, done pulse, error=0, cpu_hold falls after DONE.
- Bad checksum: same frame with last byte 0F.
  - Required: both writes occur, then error=1 and a done pulse.
  - Next start clears error to 0.
- Oversize: N=0x0101 with DEPTH_WORDS=256.
  - Required: ERR right after LEN_LO, no imem_we, error=1, in_ready=0 afterwards.
- Zero length and backpressure:
  - Frame 00 00 00 gives done, error=0, words_loaded=0.
  - Repeat the normal frame with in_valid toggling every other cycle; required writes are identical to the normal-load case.
- Reset mid-load: assert rst_n=0 after 6 payload bytes.
  - Required: all outputs 0 asynchronously, no further writes.
  - After release, a full normal frame loads correctly.
- start during busy: pulse start in the DATA state; it is ignored and the load completes unchanged.

Source files
------------

// File: rtl/instr_mem_loader.sv
// Byte-stream instruction-memory loader: parses a length-prefixed frame, assembles
// big-endian 32-bit words, writes them to consecutive addresses and holds the CPU meanwhile.
module instr_mem_loader #(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = {ADDR_W{1'b0}},
  parameter int                DEPTH_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_CHK    = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_e;

  localparam logic [16:0] DEPTH_L = 17'(DEPTH_WORDS);

  state_e            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [31:0]       shift_q, shift_d;
  logic [7:0]        chk_q, chk_d;
  logic [15:0]       wl_q, wl_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              hold_q, hold_d;
  logic              err_q, err_d;

  logic              ready_s;
  logic              xfer_s;
  logic [16:0]       n_ext_s;
  logic [15:0]       wl_inc_s;

  assign ready_s  = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                    (state_q == S_DATA)   || (state_q == S_CHK);
  assign xfer_s   = in_valid & ready_s;
  assign n_ext_s  = {1'b0, len_q[15:8], in_data};
  assign wl_inc_s = wl_q + 16'd1;

  // State and datapath registers; reset abandons any load in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= 16'd0;
      cnt_q   <= 2'd0;
      shift_q <= 32'd0;
      chk_q   <= 8'd0;
      wl_q    <= 16'd0;
      we_q    <= 1'b0;
      addr_q  <= {ADDR_W{1'b0}};
      wdata_q <= 32'd0;
      hold_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      chk_q   <= chk_d;
      wl_q    <= wl_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
    end
  end

  // Next-state and datapath logic for the frame parser.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    chk_d   = chk_q;
    wl_d    = wl_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LEN_HI;
          hold_d  = 1'b1;
          err_d   = 1'b0;
          wl_d    = 16'd0;
          chk_d   = 8'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LEN_HI: begin
        if (xfer_s) begin
          len_d[15:8] = in_data;
          state_d     = S_LEN_LO;
        end else begin
          state_d = S_LEN_HI;
        end
      end
      S_LEN_LO: begin
        if (xfer_s) begin
          len_d[7:0] = in_data;
          cnt_d      = 2'd0;
          if (n_ext_s > DEPTH_L) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else if (n_ext_s == 17'd0) begin
            state_d = S_CHK;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_LEN_LO;
        end
      end
      S_DATA: begin
        if (xfer_s) begin
          shift_d = {shift_q[23:0], in_data};
          chk_d   = chk_q ^ in_data;
          cnt_d   = cnt_q + 2'd1;
          // The write issues on the 4th byte's edge so the byte counter never stalls.
          if (cnt_q == 2'd3) begin
            we_d    = 1'b1;
            wdata_d = {shift_q[23:0], in_data};
            addr_d  = BASE_ADDR + ADDR_W'({wl_q, 2'b00});
            wl_d    = wl_inc_s;
            if (wl_inc_s == len_q) begin
              state_d = S_CHK;
            end else begin
              state_d = S_DATA;
            end
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_CHK: begin
        if (xfer_s) begin
          if (in_data == chk_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end else begin
          state_d = S_CHK;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        hold_d  = 1'b0;
      end
      S_ERR: begin
        state_d = S_IDLE;
        hold_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        hold_d  = 1'b0;
      end
    endcase
  end

  assign in_ready     = ready_s;
  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign cpu_hold     = hold_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE) || (state_q == S_ERR);
  assign error        = err_q;
  assign words_loaded = wl_q;

endmodule
